// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_param
// Brief    : Parametrised SPI master (CPOL/CPHA modes 0-3, runtime divider,
//            multi-CS, CS-held bursts). Define SPI_LSB_FIRST_EN to add
//            lsb_first_i for LSB-first transfers.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int CS_NUM = 1,
    parameter int DIV_W  = 8,
    localparam int c_sel_w = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cpol_i,
    input  logic                cpha_i,
    input  logic [DIV_W-1:0]    clk_div_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    input  logic [DATA_W-1:0]   tx_data_i,
    input  logic [c_sel_w-1:0]  tx_cs_sel_i,
    input  logic                tx_last_i,
`ifdef SPI_LSB_FIRST_EN
    input  logic                lsb_first_i,
`endif
    output logic [DATA_W-1:0]   rx_data_o,
    output logic                rx_valid_o,
    output logic                busy_o,
    output logic                spi_clk_o,
    output logic                spi_mosi_o,
    output logic [CS_NUM-1:0]   spi_cs_o,
    input  logic                spi_miso_i
);
    localparam int                c_hp_w    = $clog2(2 * DATA_W);
    localparam logic [c_hp_w-1:0] c_hp_last = c_hp_w'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_XFER   = 3'd2,
        S_TRAIL  = 3'd3,
        S_LINGER = 3'd4
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_hcnt;
    logic [c_hp_w-1:0]   r_hp;
    logic [CS_NUM-1:0]   r_cs;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_last;
    logic                r_lsb;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_ready;
    logic                r_rx_valid;
    logic                r_busy;

    logic                w_lsb_in;
    logic                w_accept;
    logic                w_hp_end;
    logic                w_lead_edge;
    logic                w_sample;
    logic                w_shift;
    logic                w_first_bit;
    logic                w_cur_bit;
    logic                w_next_bit;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_next;
    logic [CS_NUM-1:0]   w_cs_dec;

`ifdef SPI_LSB_FIRST_EN
    assign w_lsb_in = lsb_first_i;
`else
    assign w_lsb_in = 1'b0;
`endif

    assign w_accept    = tx_valid_i & r_ready;
    assign w_hp_end    = (r_hcnt == r_div);
    // Edge k closes half-period k; even k moves SCLK away from CPOL.
    assign w_lead_edge = ~r_hp[0];
    assign w_sample    = w_hp_end & (w_lead_edge ^ r_cpha);
    assign w_shift     = w_hp_end & ~(w_lead_edge ^ r_cpha);

    assign w_first_bit = w_lsb_in ? tx_data_i[0] : tx_data_i[DATA_W-1];
    assign w_tx_shift  = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_cur_bit   = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign w_next_bit  = r_lsb ? w_tx_shift[0] : w_tx_shift[DATA_W-1];
    assign w_rx_next   = r_lsb ? {spi_miso_i, r_rx[DATA_W-1:1]}
                               : {r_rx[DATA_W-2:0], spi_miso_i};

    // Out-of-range selects leave every chip select high.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            if (tx_cs_sel_i == c_sel_w'(i)) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_div      <= '0;
            r_hcnt     <= '0;
            r_hp       <= '0;
            r_cs       <= '1;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_last     <= 1'b0;
            r_lsb      <= 1'b0;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b0;
            r_ready    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx    <= tx_data_i;
                r_rx    <= '0;
                r_cpol  <= cpol_i;
                r_cpha  <= cpha_i;
                r_div   <= clk_div_i;
                r_last  <= tx_last_i;
                r_lsb   <= w_lsb_in;
                r_mosi  <= w_first_bit;
                r_sclk  <= cpol_i;
                r_hcnt  <= '0;
                r_hp    <= '0;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_sclk <= cpol_i;
                    if (w_accept) begin
                        r_cs    <= w_cs_dec;
                        r_state <= S_LEAD;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (w_hp_end) begin
                        r_hcnt  <= '0;
                        r_hp    <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_hp_end) begin
                        r_hcnt <= '0;
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_shift) begin
                            r_tx   <= w_tx_shift;
                            r_mosi <= r_cpha ? w_cur_bit : w_next_bit;
                        end
                        if (r_hp == c_hp_last) begin
                            r_sclk     <= r_cpol;
                            r_rx_valid <= 1'b1;
                            // In CPHA=1 the final sample lands on this very edge.
                            r_rx_data  <= r_cpha ? w_rx_next : r_rx;
                            if (r_last) begin
                                r_state <= S_TRAIL;
                            end else begin
                                r_state <= S_LINGER;
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_sclk <= ~r_sclk;
                            r_hp   <= r_hp + 1'b1;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (w_hp_end) begin
                        r_hcnt  <= '0;
                        r_cs    <= '1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_LINGER: begin
                    if (w_accept) begin
                        r_state <= S_XFER;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o = r_ready;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign busy_o     = r_busy;
    assign spi_clk_o  = r_sclk;
    assign spi_mosi_o = r_mosi;
    assign spi_cs_o   = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// Directed bench for spi_master_param (DATA_W=8, CS_NUM=4) with a bench-side
// SPI slave model that returns programmed words and captures MOSI.
module tb_spi_master_param;
    localparam int LIMIT = 10000;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       cpol, cpha, tx_valid, tx_last;
    logic [7:0] clk_div, tx_data;
    logic [1:0] tx_cs_sel;
    logic       tx_ready, rx_valid, busy, spi_clk, spi_mosi;
    logic [7:0] rx_data;
    logic [3:0] spi_cs;
    logic       miso = 1'b0;
    logic       loopback;
    logic       miso_w;
    logic       cs_low;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_first;
`endif

    assign miso_w = loopback ? spi_mosi : miso;
    assign cs_low = (spi_cs != 4'hF);

    spi_master_param #(.DATA_W(8), .CS_NUM(4), .DIV_W(8)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .clk_div_i   (clk_div),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .tx_data_i   (tx_data),
        .tx_cs_sel_i (tx_cs_sel),
        .tx_last_i   (tx_last),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first_i (lsb_first),
`endif
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .busy_o      (busy),
        .spi_clk_o   (spi_clk),
        .spi_mosi_o  (spi_mosi),
        .spi_cs_o    (spi_cs),
        .spi_miso_i  (miso_w)
    );

    always #5 sys_clk = ~sys_clk;

    int ncyc = 0;
    always @(posedge sys_clk) ncyc <= ncyc + 1;

    int n_err = 0;
    int n_checks = 0;
    int acc_cyc = 0;

    // Slave model: CPHA=0 presents bits at CS fall / trailing edges,
    // CPHA=1 on leading edges; captures MOSI on the opposite edge.
    logic       m_cpha = 1'b0;
    logic [7:0] s_words [4];
    logic [7:0] s_rx_words [4];
    logic [7:0] s_rx = 8'h00;
    logic [1:0] s_word = 2'd0;
    int         s_bit = 0;
    logic       s_prev_cs = 1'b0;
    logic       s_prev_clk = 1'b1;

    always @(spi_clk or cs_low) begin
        if (cs_low && !s_prev_cs) begin
            s_word = 2'd0;
            s_bit  = 0;
            s_rx   = 8'h00;
            if (!m_cpha) miso = s_words[0][7];
        end else if (cs_low && (spi_clk !== s_prev_clk)) begin
            if ((spi_clk != cpol) ^ m_cpha) begin
                s_rx = {s_rx[6:0], spi_mosi};
                if (m_cpha) begin
                    s_bit++;
                    if (s_bit == 8) begin
                        s_rx_words[s_word] = s_rx;
                        s_word++;
                        s_bit = 0;
                    end
                end
            end else if (m_cpha) begin
                miso = s_words[s_word][7-s_bit];
            end else begin
                s_bit++;
                if (s_bit == 8) begin
                    s_rx_words[s_word] = s_rx;
                    s_word++;
                    s_bit = 0;
                end
                miso = s_words[s_word][7-s_bit];
            end
        end
        s_prev_cs  = cs_low;
        s_prev_clk = spi_clk;
    end

    // Output monitor; statistics restart whenever epoch moves.
    int         epoch = 0;
    int         seen_epoch = 0;
    int         rx_cnt, rx_cyc, cs_first, cs_last, cs_cnt, rises, rdy_rise;
    int         rise_cyc [2];
    logic [7:0] rx_words [4];
    logic [3:0] cs_bits;
    logic       multi_cs;
    logic       m_prev_clk = 1'b1;
    logic       m_prev_rdy = 1'b0;

    always @(negedge sys_clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            rx_cnt = 0; rx_cyc = -1; cs_first = -1; cs_last = -1; cs_cnt = 0;
            rises = 0; rdy_rise = -1; rise_cyc[0] = -1; rise_cyc[1] = -1;
            cs_bits = 4'hF; multi_cs = 1'b0;
        end
        if (rx_valid) begin
            if (rx_cnt < 4) rx_words[rx_cnt] = rx_data;
            rx_cnt++;
            rx_cyc = ncyc;
        end
        if (spi_cs != 4'hF) begin
            if (cs_first < 0) cs_first = ncyc;
            cs_last = ncyc;
            cs_cnt++;
        end
        cs_bits = cs_bits & spi_cs;
        if ($countones(~spi_cs) > 1) multi_cs = 1'b1;
        if (spi_clk && !m_prev_clk) begin
            if (rises < 2) rise_cyc[rises] = ncyc;
            rises++;
        end
        if (tx_ready && !m_prev_rdy && rdy_rise < 0) rdy_rise = ncyc;
        m_prev_clk = spi_clk;
        m_prev_rdy = tx_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        epoch++;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] sel, input logic last,
                        input logic [7:0] div);
        int n = 0;
        tx_data = d; tx_cs_sel = sel; tx_last = last; clk_div = div; tx_valid = 1'b1;
        while (!tx_ready && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        check("accept_wait", 32'(n < LIMIT), 32'd1);
        acc_cyc = ncyc;
        @(negedge sys_clk);
        // Later input changes must not disturb the word in flight.
        tx_valid = 1'b0; tx_data = ~d; tx_cs_sel = sel + 2'd1; tx_last = ~last;
        clk_div = div + 8'd3;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(tx_ready && !busy) && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        check("done_wait", 32'(n < LIMIT), 32'd1);
        @(negedge sys_clk);
        #1;
    endtask

    task automatic run_mode(input logic pol, input logic pha, input logic [7:0] d,
                            input logic [7:0] sd);
        cpol = pol; cpha = pha; m_cpha = pha; s_words[0] = sd;
        repeat (2) @(negedge sys_clk);
        check($sformatf("m%0d%0d_idle_before", pol, pha), 32'(spi_clk), 32'(pol));
        clear_stats();
        send(d, 2'd1, 1'b1, 8'd1);
        wait_done();
        check($sformatf("m%0d%0d_rx", pol, pha), 32'(rx_words[0]), 32'(sd));
        check($sformatf("m%0d%0d_mosi", pol, pha), 32'(s_rx_words[0]), 32'(d));
        check($sformatf("m%0d%0d_rises", pol, pha), rises, 32'd8);
        check($sformatf("m%0d%0d_rx_cycle", pol, pha), rx_cyc - acc_cyc, 32'd35);
        check($sformatf("m%0d%0d_idle_after", pol, pha), 32'(spi_clk), 32'(pol));
    endtask

    initial begin
        int n;
        sys_rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
        clk_div = 8'd0; tx_data = 8'd0; tx_cs_sel = 2'd0; loopback = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            s_words[i] = 8'h00;
            s_rx_words[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_cs", 32'(spi_cs), 32'hF);
        check("rst_sclk", 32'(spi_clk), 32'd1);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("ready_after_rst", 32'(tx_ready), 32'd1);

        // Mode 0 with full timing checks
        run_mode(1'b0, 1'b0, 8'hA5, 8'h3C);
        check("m00_cs_first", cs_first - acc_cyc, 32'd1);
        check("m00_cs_last", cs_last - acc_cyc, 32'd36);
        check("m00_ready_back", rdy_rise - acc_cyc, 32'd37);
        check("m00_half_period", rise_cyc[1] - rise_cyc[0], 32'd4);
        check("m00_cs_bits", 32'(cs_bits), 32'hD);
        check("m00_one_cs", 32'(multi_cs), 32'd0);

        run_mode(1'b0, 1'b1, 8'h5A, 8'hC3);
        run_mode(1'b1, 1'b0, 8'hC3, 8'h5A);
        run_mode(1'b1, 1'b1, 8'h5A, 8'hC3);

        // Burst on CS2; later selects are ignored while CS is held
        run_mode(1'b0, 1'b0, 8'h0F, 8'hF0);
        s_words[0] = 8'hA1; s_words[1] = 8'hB2; s_words[2] = 8'hC3;
        clear_stats();
        send(8'h11, 2'd2, 1'b0, 8'd0);
        send(8'h22, 2'd0, 1'b0, 8'd0);
        send(8'h33, 2'd1, 1'b1, 8'd0);
        wait_done();
        check("burst_rx_cnt", rx_cnt, 32'd3);
        check("burst_rx0", 32'(rx_words[0]), 32'hA1);
        check("burst_rx1", 32'(rx_words[1]), 32'hB2);
        check("burst_rx2", 32'(rx_words[2]), 32'hC3);
        check("burst_mosi0", 32'(s_rx_words[0]), 32'h11);
        check("burst_mosi1", 32'(s_rx_words[1]), 32'h22);
        check("burst_mosi2", 32'(s_rx_words[2]), 32'h33);
        check("burst_cs_bits", 32'(cs_bits), 32'hB);
        check("burst_cs_continuous", cs_cnt, cs_last - cs_first + 1);
        check("burst_one_cs", 32'(multi_cs), 32'd0);

        // Reset in the middle of a word
        clear_stats();
        send(8'hFF, 2'd3, 1'b1, 8'd1);
        n = 0;
        while (rises < 4 && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        check("midrst_reach_bit4", 32'(n < LIMIT), 32'd1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_cs", 32'(spi_cs), 32'hF);
        check("midrst_sclk", 32'(spi_clk), 32'd1);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (40) @(negedge sys_clk);
        #1;
        check("midrst_no_rx", rx_cnt, 32'd0);

        // Divider extremes
        s_words[0] = 8'h96;
        clear_stats();
        send(8'h69, 2'd0, 1'b1, 8'd0);
        wait_done();
        check("div0_half_period", rise_cyc[1] - rise_cyc[0], 32'd2);
        check("div0_rx_cycle", rx_cyc - acc_cyc, 32'd18);
        check("div0_rx", 32'(rx_words[0]), 32'h96);
        clear_stats();
        send(8'h81, 2'd0, 1'b1, 8'd255);
        wait_done();
        check("div255_half_period", rise_cyc[1] - rise_cyc[0], 32'd512);
        check("div255_rx_cycle", rx_cyc - acc_cyc, 32'd4353);
        check("div255_cs_last", cs_last - acc_cyc, 32'd4608);
        check("div255_mosi", 32'(s_rx_words[0]), 32'h81);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        loopback  = 1'b1;
        clear_stats();
        send(8'h01, 2'd0, 1'b1, 8'd1);
        wait_done();
        check("lsb_rx_loop", 32'(rx_words[0]), 32'h01);
        check("lsb_mosi_order", 32'(s_rx_words[0]), 32'h80);
        lsb_first = 1'b0;
        loopback  = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Synthesizable, parametrised SPI master that replaces the software-driven SPI bit-banging path with a hardware engine.
- Accepts parallel words over a valid/ready handshake and shifts them out on SCLK/MOSI while capturing MISO.
- Supports all four CPOL/CPHA modes, a runtime clock divider, multiple chip selects and multi-word bursts with CS held.
- Sits between a host-side command source (DPI bridge or bus register block) and the SPI pads, clocked by sys_clk.

Parameters:
DATA_W, 8, bits per word (2..32)
CS_NUM, 1, number of chip-select outputs (1..8)
DIV_W, 8, width of clock-divider input

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  synchronous active-low reset
cpol_i  input  1  SCLK idle level; latched at word accept
cpha_i  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept
clk_div_i  input  DIV_W  SCLK half-period = clk_div_i+1 sys_clk cycles (H); latched at accept
tx_valid_i  input  1  word available
tx_ready_o  output  1  engine can accept a word
tx_data_i  input  DATA_W  word to send, MSB first
tx_cs_sel_i  input  $clog2(CS_NUM) (min 1)  chip-select index
tx_last_i  input  1  1 = deassert CS after this word
rx_data_o  output  DATA_W  received word
rx_valid_o  output  1  one-cycle pulse, rx_data_o valid
busy_o  output  1  any CS asserted or transfer in progress
spi_clk_o  output  1  SCLK
spi_mosi_o  output  1  MOSI
spi_cs_o  output  CS_NUM  active-low chip selects
spi_miso_i  input  1  MISO

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge): spi_cs_o all 1, spi_clk_o=1, spi_mosi_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0, state IDLE. tx_ready_o rises the first cycle after reset release.
- Reset mid-transfer aborts immediately: no rx_valid_o pulse, all CS high on the next edge.
- States:
  - IDLE: tx_ready_o=1, spi_clk_o=cpol_i. Accept (valid&ready) latches data, cs_sel, last, cpol, cpha and div, then goes to LEAD.
  - LEAD: selected CS low for H cycles, SCLK at CPOL. For CPHA=0, MOSI = data MSB during LEAD.
  - XFER: 2*DATA_W half-periods of H cycles; SCLK toggles at the start of each half-period after the first.
    - CPHA=0: sample MISO on leading edges; shift MOSI on trailing edges.
    - CPHA=1: drive MOSI on leading edges; sample on trailing edges.
    - SCLK returns to CPOL at XFER end.
  - Exit XFER: rx_valid_o pulses one cycle with the assembled word (first sampled bit = MSB). Then:
    - last=1: go to TRAIL.
    - last=0: go to LINGER.
  - TRAIL: CS low for H cycles, then CS high and back to IDLE.
  - LINGER: CS held low, tx_ready_o=1, no timeout. An accepted word goes straight to XFER. Its tx_cs_sel_i is ignored (burst stays on the current CS), but cpol, cpha and div are re-latched.
- Timing, single word (accept at cycle 0): CS low cycles 1..2H+2*DATA_W*H; rx_valid_o at cycle 1+H+2*DATA_W*H; tx_ready_o high again at cycle 1+2H+2*DATA_W*H.
- tx_cs_sel_i >= CS_NUM: no CS asserts, but SCLK/MOSI timing is unchanged and rx_valid_o still pulses.
- Exactly one CS is low at a time.
- Input changes after accept have no effect on the current word.
- rx_valid_o has no back-pressure.
- busy_o=1 in every state except IDLE.
- clk_div_i=0 gives H=1, i.e. SCLK = sys_clk/2.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined: adds input port lsb_first_i (1 bit), latched at accept. When 1, words are transmitted LSB first and received bits assemble LSB first.
- Undefined: the port does not exist and operation is MSB first only.

Test Plan:
- DATA_W=8, CPOL=0, CPHA=0, div=1, send 0xA5 with last=1, MISO model returns 0x3C -> rx_data_o=0x3C pulse at cycle 35; CS low cycles 1..36; 8 rising SCLK edges; MOSI 1,0,1,0,0,1,0,1.
- Repeat for modes (CPOL,CPHA) = 01, 10, 11 with 0x5A/0xC3 -> correct sampling edge per mode; SCLK idle level equals CPOL before and after.
- Burst: 3 words 0x11, 0x22, 0x33 with last=0,0,1 on CS_NUM=4, sel=2 -> spi_cs_o[2] low continuously across all 3 words; 3 rx_valid_o pulses; other CS bits stay 1.
- Assert sys_rst_n=0 mid-XFER after 4 bits -> next edge: all CS high, SCLK=1, no rx_valid_o; tx_ready_o=1 one cycle after release.
- div=0 vs div=255 -> SCLK half-period 1 and 256 cycles; changing clk_div_i during XFER has no effect.
- With SPI_LSB_FIRST_EN and lsb_first_i=1, send 0x01 -> first MOSI bit 1, rest 0; looped-back MISO gives rx_data_o=0x01.
